monkey_collision_ctrl: RTL and testbench
========================================

MONKEY_COLLISION_CTRL -- requirements
Module: monkey_collision_ctrl

Interface
REQ-001 Parameter HOLDOFF_FRAMES, default 4, number of frames enemy collisions stay suppressed after a reported enemy hit (legal 1..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetN  input  1  reset, asynchronous, active-low.
REQ-004 startOfFrame  input  1  single-cycle pulse marking the first pixel of a frame.
REQ-005 monkeyDrawingRequest  input  1  monkey bitmap pixel is opaque; registered upstream, aligned with monkeyHitEdgeCode.
REQ-006 monkeyHitEdgeCode  input  4  {Left,Top,Right,Bottom} edge bits of the current monkey pixel.
REQ-007 floorDrawingRequest  input  1  floor or platform pixel is opaque; same pipeline alignment as the monkey inputs.
REQ-008 vineDrawingRequest  input  1  vine pixel is opaque; same alignment.
REQ-009 enemyDrawingRequest  input  1  enemy pixel is opaque; same alignment.
REQ-010 collisionFloor  output  1  one-cycle pulse: monkey overlapped floor in the last frame.
REQ-011 collisionVine  output  1  one-cycle pulse: monkey overlapped vine in the last frame.
REQ-012 collisionEnemy  output  1  one-cycle pulse: monkey overlapped enemy in the last frame and holdoff is inactive.
REQ-013 floorEdges  output  4  OR of monkeyHitEdgeCode over all monkey/floor overlap pixels of the last frame; held until the next report.
REQ-014 holdoffActive  output  1  high while in state HOLDOFF.

Function
REQ-015 An overlap pixel SHALL be any cycle in which monkeyDrawingRequest and the relevant object request are both 1.
REQ-016 Three sticky flags (floor, vine, enemy) and a 4-bit sticky edge accumulator SHALL set on overlap pixels and never clear mid-frame.
REQ-017 On a cycle with startOfFrame=1, the sticky contents SHALL be transferred to the report registers, and the outputs SHALL show them on the following cycle (latency 1 cycle after startOfFrame).
REQ-018 The pixel sampled in the startOfFrame cycle SHALL count toward the new frame: the sticky flags load that pixel's overlap value rather than 0.
REQ-019 The collision pulses SHALL be high for exactly one cycle per frame; floorEdges SHALL update only at a report and SHALL become 0 when the reported frame had no floor overlap.
REQ-020 The FSM states SHALL be ACCUM and HOLDOFF.
REQ-021 In ACCUM, a report with enemy=1 SHALL pulse collisionEnemy, go to HOLDOFF, and load the frame counter with HOLDOFF_FRAMES.
REQ-022 In HOLDOFF, collisionEnemy SHALL be forced to 0, and floor and vine reporting SHALL continue unchanged.
REQ-023 In HOLDOFF, the frame counter SHALL decrement at each startOfFrame, and the FSM SHALL return to ACCUM at the startOfFrame where the counter reaches 0.
REQ-024 An enemy overlap during the frame that ends HOLDOFF SHALL NOT be reported.
REQ-025 Two startOfFrame pulses in consecutive cycles SHALL each produce a report, the second containing only the single pixel sampled in the first.

Reset
REQ-026 On resetN=0, all outputs, sticky flags, report registers, and the frame counter SHALL be 0 and the FSM SHALL be ACCUM, immediately and regardless of clock.
REQ-027 Reset asserted mid-frame or mid-holdoff SHALL discard all accumulated state, and no pulse SHALL be emitted for the interrupted frame.
REQ-028 After reset release, no report SHALL occur before the first startOfFrame.

Configuration
REQ-029 With macro COLLISION_COUNT_EN defined, the block SHALL provide output enemyHitCount [7:0], which increments on each collisionEnemy pulse, saturates at 255, and resets to 0.
REQ-030 Without COLLISION_COUNT_EN, the enemyHitCount port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package collision_pkg SHALL hold the FSM state enum, the edge bit indices (LEFT=3, TOP=2, RIGHT=1, BOTTOM=0), and the HOLDOFF_FRAMES default.
REQ-032 Sub-module frame_sticky SHALL implement one sticky flag together with its frame-boundary load and report register, instantiated three times; the edge accumulator stays inline.

Verification
REQ-033 Floor overlap for 3 pixels with edge codes 4'h1, 4'h3, 4'h1, then startOfFrame: the next cycle shows collisionFloor=1 for 1 cycle and floorEdges=4'h3.
REQ-034 A frame with no overlaps after a floor frame: the report shows collisionFloor=0 and floorEdges=4'h0.
REQ-035 Enemy overlap in frame N: collisionEnemy pulses and holdoffActive=1; enemy overlaps in frames N+1..N+4 produce no pulse; an enemy overlap in frame N+5 pulses again.
REQ-036 Overlap present only in the startOfFrame cycle: not reported now, but reported at the next startOfFrame.
REQ-037 resetN pulsed low mid-holdoff with vine overlap pending: all outputs 0, state ACCUM, and no vine pulse at the next startOfFrame unless new overlap occurs.
REQ-038 With COLLISION_COUNT_EN and HOLDOFF_FRAMES=1, 300 enemy reports: enemyHitCount=255.

Source files
------------

// File: rtl/collision_pkg.sv
// collision_pkg: shared FSM state, edge bit positions and holdoff default for the monkey collision controller.
package collision_pkg;

    typedef enum logic {ACCUM = 1'b0, HOLDOFF = 1'b1} state_t;

    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    localparam int HOLDOFF_FRAMES_DEFAULT = 4;

endpackage

// File: rtl/frame_sticky.sv
// frame_sticky: one per-frame sticky overlap flag with its frame-boundary load and one-cycle report register.
module frame_sticky (
    input  logic clk,
    input  logic resetN,
    input  logic i_sof,
    input  logic i_hit,
    output logic o_sticky,
    output logic o_rep
);

    logic r_sticky;
    logic r_rep;

    // The start-of-frame pixel belongs to the new frame, so it seeds the flag.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sticky <= 1'b0;
            r_rep    <= 1'b0;
        end else begin
            r_sticky <= i_sof ? i_hit : (r_sticky | i_hit);
            r_rep    <= i_sof & r_sticky;
        end
    end

    assign o_sticky = r_sticky;
    assign o_rep    = r_rep;

endmodule

// File: rtl/monkey_collision_ctrl.sv
// monkey_collision_ctrl: per-frame floor/vine/enemy overlap reporting with enemy-hit holdoff.
// Optional enemyHitCount output is built when COLLISION_COUNT_EN is defined.
module monkey_collision_ctrl
    import collision_pkg::*;
#(
    parameter int HOLDOFF_FRAMES = HOLDOFF_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       monkeyDrawingRequest,
    input  logic [3:0] monkeyHitEdgeCode,
    input  logic       floorDrawingRequest,
    input  logic       vineDrawingRequest,
    input  logic       enemyDrawingRequest,
    output logic       collisionFloor,
    output logic       collisionVine,
    output logic       collisionEnemy,
    output logic [3:0] floorEdges,
    output logic       holdoffActive
`ifdef COLLISION_COUNT_EN
    ,
    output logic [7:0] enemyHitCount
`endif
);

    logic       w_floor_hit, w_vine_hit, w_enemy_hit;
    logic       w_floor_sticky_unused, w_vine_sticky_unused, w_enemy_sticky;
    logic       w_rep_floor, w_rep_vine, w_rep_enemy;
    logic [3:0] r_edge_acc, r_floor_edges;
    logic [3:0] r_cnt, w_cnt_next;
    state_t     r_state, w_state_next;
    logic       r_enemy_ok;

    assign w_floor_hit = monkeyDrawingRequest & floorDrawingRequest;
    assign w_vine_hit  = monkeyDrawingRequest & vineDrawingRequest;
    assign w_enemy_hit = monkeyDrawingRequest & enemyDrawingRequest;

    frame_sticky u_floor (
        .clk(clk), .resetN(resetN), .i_sof(startOfFrame), .i_hit(w_floor_hit),
        .o_sticky(w_floor_sticky_unused), .o_rep(w_rep_floor)
    );

    frame_sticky u_vine (
        .clk(clk), .resetN(resetN), .i_sof(startOfFrame), .i_hit(w_vine_hit),
        .o_sticky(w_vine_sticky_unused), .o_rep(w_rep_vine)
    );

    frame_sticky u_enemy (
        .clk(clk), .resetN(resetN), .i_sof(startOfFrame), .i_hit(w_enemy_hit),
        .o_sticky(w_enemy_sticky), .o_rep(w_rep_enemy)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_edge_acc    <= 4'h0;
            r_floor_edges <= 4'h0;
        end else begin
            r_edge_acc <= (startOfFrame ? 4'h0 : r_edge_acc) | (w_floor_hit ? monkeyHitEdgeCode : 4'h0);
            if (startOfFrame)
                r_floor_edges <= r_edge_acc;
        end
    end

    // r_enemy_ok remembers whether the state was ACCUM when the frame being reported closed.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ACCUM;
            r_cnt      <= 4'h0;
            r_enemy_ok <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_enemy_ok <= (r_state == ACCUM);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (startOfFrame && r_state == ACCUM && w_enemy_sticky) begin
            w_state_next = HOLDOFF;
            w_cnt_next   = 4'(HOLDOFF_FRAMES);
        end else if (startOfFrame && r_state == HOLDOFF) begin
            w_cnt_next   = r_cnt - 4'd1;
            w_state_next = (r_cnt == 4'd1) ? ACCUM : HOLDOFF;
        end
    end

    always_comb begin
        collisionFloor = w_rep_floor;
        collisionVine  = w_rep_vine;
        collisionEnemy = w_rep_enemy & r_enemy_ok;
        floorEdges     = r_floor_edges;
        holdoffActive  = (r_state == HOLDOFF);
    end

`ifdef COLLISION_COUNT_EN
    logic [7:0] r_hit_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_hit_cnt <= 8'h00;
        else if (collisionEnemy && r_hit_cnt != 8'hFF)
            r_hit_cnt <= r_hit_cnt + 8'h01;
    end

    assign enemyHitCount = r_hit_cnt;
`endif

endmodule

// File: tb/tb_monkey_collision_ctrl.sv
// tb_monkey_collision_ctrl: frame-level reference model with per-cycle compare, directed scenarios and random traffic.
module tb_monkey_collision_ctrl;

`ifdef COLLISION_COUNT_EN
    localparam int HF = 1;
`else
    localparam int HF = 4;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       sof = 1'b0, md = 1'b0, fl = 1'b0, vi = 1'b0, en = 1'b0;
    logic [3:0] code = 4'h0;
    logic       o_floor, o_vine, o_enemy, o_hold;
    logic [3:0] o_edges;
`ifdef COLLISION_COUNT_EN
    logic [7:0] o_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    monkey_collision_ctrl #(.HOLDOFF_FRAMES(HF)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .monkeyDrawingRequest(md), .monkeyHitEdgeCode(code),
        .floorDrawingRequest(fl), .vineDrawingRequest(vi), .enemyDrawingRequest(en),
        .collisionFloor(o_floor), .collisionVine(o_vine), .collisionEnemy(o_enemy),
        .floorEdges(o_edges), .holdoffActive(o_hold)
`ifdef COLLISION_COUNT_EN
        , .enemyHitCount(o_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: what was seen in the current frame, and how many frames of holdoff remain.
    bit       f_floor = 0, f_vine = 0, f_enemy = 0;
    bit [3:0] f_edges = 0;
    int       left = 0;
    bit       e_floor = 0, e_vine = 0, e_enemy = 0, e_hold = 0;
    bit [3:0] e_edges = 0;
    int       e_cnt = 0;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            f_floor = 0; f_vine = 0; f_enemy = 0; f_edges = 0; left = 0;
            e_floor = 0; e_vine = 0; e_enemy = 0; e_hold = 0; e_edges = 0; e_cnt = 0;
        end else begin
            e_floor = 0; e_vine = 0; e_enemy = 0;
            if (sof) begin
                e_floor = f_floor;
                e_vine  = f_vine;
                e_edges = f_edges;
                e_enemy = f_enemy && left == 0;
                if (e_enemy) left = HF;
                else if (left > 0) left = left - 1;
                f_floor = 0; f_vine = 0; f_enemy = 0; f_edges = 0;
            end
            if (md && fl) begin f_floor = 1; f_edges = f_edges | code; end
            if (md && vi) f_vine = 1;
            if (md && en) f_enemy = 1;
            e_hold = left > 0;
            if (e_enemy && e_cnt < 255) e_cnt = e_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_floor", int'(o_floor), int'(e_floor));
            chk("m_vine",  int'(o_vine),  int'(e_vine));
            chk("m_enemy", int'(o_enemy), int'(e_enemy));
            chk("m_edges", int'(o_edges), int'(e_edges));
            chk("m_hold",  int'(o_hold),  int'(e_hold));
`ifdef COLLISION_COUNT_EN
            chk("m_cnt",   int'(o_cnt),   e_cnt);
`endif
        end
    end

    task automatic cyc(input bit s, input bit m, input bit [3:0] c, input bit f, input bit v, input bit e);
        sof = s; md = m; code = c; fl = f; vi = v; en = e;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_floor"}, int'(o_floor), 0);
        chk({tag, "_vine"},  int'(o_vine),  0);
        chk({tag, "_enemy"}, int'(o_enemy), 0);
        chk({tag, "_edges"}, int'(o_edges), 0);
        chk({tag, "_hold"},  int'(o_hold),  0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        resetN = 1'b1;
        cmp_en = 1'b1;
        repeat (3) cyc(0, 0, 4'h0, 0, 0, 0);
        chk_all_zero("no_sof");

        // Three floor pixels with edges 1,3,1 report as edges 3.
        cyc(1, 0, 4'h0, 0, 0, 0);
        cyc(0, 1, 4'h1, 1, 0, 0);
        cyc(0, 1, 4'h3, 1, 0, 0);
        cyc(0, 1, 4'h1, 1, 0, 0);
        cyc(1, 0, 4'h0, 0, 0, 0);
        chk("floor_pulse", int'(o_floor), 1);
        chk("floor_edges", int'(o_edges), 3);
        cyc(0, 0, 4'h0, 0, 0, 0);
        chk("floor_one_cycle", int'(o_floor), 0);
        chk("edges_held", int'(o_edges), 3);

        // Empty frame clears the edges.
        cyc(0, 1, 4'hF, 0, 0, 0);
        cyc(1, 0, 4'h0, 0, 0, 0);
        chk("empty_floor", int'(o_floor), 0);
        chk("empty_edges", int'(o_edges), 0);

        // Enemy hit, holdoff for HF frames, then hit again.
        cyc(0, 1, 4'h0, 0, 0, 1);
        cyc(1, 0, 4'h0, 0, 0, 0);
        chk("enemy_first", int'(o_enemy), 1);
        chk("hold_on", int'(o_hold), 1);
        for (int k = 0; k < HF; k++) begin
            cyc(0, 1, 4'h0, 0, 0, 1);
            cyc(1, 0, 4'h0, 0, 0, 0);
            chk("enemy_suppressed", int'(o_enemy), 0);
        end
        chk("hold_off", int'(o_hold), 0);
        cyc(0, 1, 4'h0, 0, 0, 1);
        cyc(1, 0, 4'h0, 0, 0, 0);
        chk("enemy_again", int'(o_enemy), 1);

        // Overlap only in the start-of-frame pixel belongs to the next report.
        cyc(1, 1, 4'h0, 0, 1, 0);
        chk("sof_pix_now", int'(o_vine), 0);
        cyc(1, 0, 4'h0, 0, 0, 0);
        chk("sof_pix_next", int'(o_vine), 1);

        // Reset mid-frame discards a pending vine overlap.
        cyc(0, 1, 4'h0, 0, 0, 1);
        cyc(1, 0, 4'h0, 0, 0, 0);
        cyc(0, 1, 4'h0, 0, 1, 0);
        #2 resetN = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        resetN = 1'b1;
        cyc(0, 0, 4'h0, 0, 0, 0);
        cyc(1, 0, 4'h0, 0, 0, 0);
        chk("rst_no_vine", int'(o_vine), 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                #2 resetN = 1'b0;
                #2 resetN = 1'b1;
            end
            cyc($urandom_range(0, 11) == 0, 1'($urandom), 4'($urandom), 1'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end

`ifdef COLLISION_COUNT_EN
        for (int i = 0; i < 600; i++) begin
            cyc(0, 1, 4'h0, 0, 0, 1);
            cyc(1, 0, 4'h0, 0, 0, 0);
        end
        cyc(0, 0, 4'h0, 0, 0, 0);
        chk("count_sat", int'(o_cnt), 255);
`endif

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
